// File: rtl/phase_sequencer.sv
// Multi-phase traffic signal sequencer with actuated green, clearance
// intervals, latched vehicle/pedestrian requests and a BCD walk countdown.
module phase_sequencer #(
   parameter int unsigned NUM_PHASES   = 4,
   parameter int unsigned MIN_GREEN    = 10,
   parameter int unsigned MAX_GREEN    = 40,
   parameter int unsigned YELLOW_TIME  = 4,
   parameter int unsigned ALL_RED_TIME = 2,
   parameter int unsigned WALK_TIME    = 7
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          tick,
   input  logic [NUM_PHASES-1:0]         car_sensor,
   input  logic [NUM_PHASES-1:0]         pedestrian_button,
   output logic [NUM_PHASES-1:0]         green_light,
   output logic [NUM_PHASES-1:0]         yellow_light,
   output logic [NUM_PHASES-1:0]         red_light,
   output logic [NUM_PHASES-1:0]         walk_light,
   output logic [NUM_PHASES-1:0]         hand_light,
   output logic [$clog2(NUM_PHASES)-1:0] active_phase,
   output logic [7:0]                    countdown_bcd,
   output logic [NUM_PHASES-1:0]         request_pending
);

   localparam int unsigned AW   = $clog2(NUM_PHASES);
   localparam int unsigned TMAX = (YELLOW_TIME > ALL_RED_TIME) ? YELLOW_TIME : ALL_RED_TIME;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned EW   = $clog2(MAX_GREEN + 1);
   localparam int unsigned WW   = 7;

   typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW} state_t;

   state_t                r_state,   w_state_nxt;
   logic [TW-1:0]         r_timer,   w_timer_nxt;
   logic [EW-1:0]         r_elapsed, w_elapsed_nxt, w_el_inc;
   logic [WW-1:0]         r_walk,    w_walk_nxt;
   logic [AW-1:0]         r_active,  w_active_nxt, w_pick;
   logic [NUM_PHASES-1:0] r_req,     w_req_nxt;
   logic [NUM_PHASES-1:0] r_ped,     w_ped_nxt;
   logic                  w_found, w_others, w_green_entry;

   logic [NUM_PHASES-1:0] r_green, r_yellow, r_red, r_walk_l, r_hand;
   logic [NUM_PHASES-1:0] w_onehot, w_green_nxt, w_yellow_nxt, w_walk_l_nxt;
   logic [7:0]            r_bcd, w_bcd_nxt;

   // Cyclic search for the next requesting phase, starting after the active one
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
         if (!w_found && r_req[AW'((32'(r_active) + k) % NUM_PHASES)]) begin
            w_found = 1'b1;
            w_pick  = AW'((32'(r_active) + k) % NUM_PHASES);
         end
      end
   end

   assign w_others = |(r_req & ~(NUM_PHASES'(1) << r_active));
   assign w_el_inc = (r_elapsed >= EW'(MAX_GREEN)) ? r_elapsed : r_elapsed + EW'(1);

   // Next-state logic
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_elapsed_nxt = r_elapsed;
      w_walk_nxt    = r_walk;
      w_active_nxt  = r_active;
      w_green_entry = 1'b0;
      case (r_state)
         S_ALL_RED: begin
            if (tick) begin
               if (r_timer == TW'(1)) begin
                  w_state_nxt   = S_GREEN;
                  w_timer_nxt   = '0;
                  w_active_nxt  = w_found ? w_pick : '0;
                  w_green_entry = 1'b1;
                  w_elapsed_nxt = '0;
                  w_walk_nxt    = (r_ped[w_active_nxt] | pedestrian_button[w_active_nxt]) ?
                                  WW'(WALK_TIME) : '0;
               end else begin
                  w_timer_nxt = r_timer - TW'(1);
               end
            end
         end
         S_GREEN: begin
            if (tick) begin
               w_elapsed_nxt = w_el_inc;
               if (r_walk != '0) w_walk_nxt = r_walk - WW'(1);
               if ((w_el_inc >= EW'(MIN_GREEN)) && w_others &&
                   (!car_sensor[r_active] || (w_el_inc >= EW'(MAX_GREEN)))) begin
                  w_state_nxt = S_YELLOW;
                  w_timer_nxt = TW'(YELLOW_TIME);
                  w_walk_nxt  = '0;
               end
            end
         end
         S_YELLOW: begin
            if (tick) begin
               if (r_timer == TW'(1)) begin
                  w_state_nxt = S_ALL_RED;
                  w_timer_nxt = TW'(ALL_RED_TIME);
               end else begin
                  w_timer_nxt = r_timer - TW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_ALL_RED;
            w_timer_nxt = TW'(ALL_RED_TIME);
         end
      endcase
   end

   // Request latching; the served phase is cleared on green entry, clear wins
   always_comb begin
      w_req_nxt = r_req;
      w_ped_nxt = r_ped;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
         if ((car_sensor[i] | pedestrian_button[i]) &&
             !((r_state == S_GREEN) && (AW'(i) == r_active)))
            w_req_nxt[i] = 1'b1;
         if (pedestrian_button[i]) w_ped_nxt[i] = 1'b1;
      end
      if (w_green_entry) begin
         w_req_nxt[w_active_nxt] = 1'b0;
         w_ped_nxt[w_active_nxt] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_ALL_RED;
         r_timer   <= TW'(ALL_RED_TIME);
         r_elapsed <= '0;
         r_walk    <= '0;
         r_active  <= '0;
         r_req     <= '0;
         r_ped     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_elapsed <= w_elapsed_nxt;
         r_walk    <= w_walk_nxt;
         r_active  <= w_active_nxt;
         r_req     <= w_req_nxt;
         r_ped     <= w_ped_nxt;
      end
   end

   // Head decode from next state so lights are registered alongside the FSM
   assign w_onehot     = NUM_PHASES'(1) << w_active_nxt;
   assign w_green_nxt  = (w_state_nxt == S_GREEN)  ? w_onehot : '0;
   assign w_yellow_nxt = (w_state_nxt == S_YELLOW) ? w_onehot : '0;
   assign w_walk_l_nxt = ((w_state_nxt == S_GREEN) && (w_walk_nxt != '0)) ? w_onehot : '0;
   assign w_bcd_nxt    = {4'(w_walk_nxt / WW'(10)), 4'(w_walk_nxt % WW'(10))};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_green  <= '0;
         r_yellow <= '0;
         r_red    <= '1;
         r_walk_l <= '0;
         r_hand   <= '1;
         r_bcd    <= '0;
      end else begin
         r_green  <= w_green_nxt;
         r_yellow <= w_yellow_nxt;
         r_red    <= ~(w_green_nxt | w_yellow_nxt);
         r_walk_l <= w_walk_l_nxt;
         r_hand   <= ~w_walk_l_nxt;
         r_bcd    <= w_bcd_nxt;
      end
   end

   assign green_light     = r_green;
   assign yellow_light    = r_yellow;
   assign red_light       = r_red;
   assign walk_light      = r_walk_l;
   assign hand_light      = r_hand;
   assign countdown_bcd   = r_bcd;
   assign active_phase    = r_active;
   assign request_pending = r_req;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with default parameters and tick held high.
module tb_phase_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       tick = 1'b1;
   logic [3:0] car_sensor = '0;
   logic [3:0] pedestrian_button = '0;
   logic [3:0] green_light, yellow_light, red_light, walk_light, hand_light;
   logic [1:0] active_phase;
   logic [7:0] countdown_bcd;
   logic [3:0] request_pending;

   int n_checks = 0;
   int n_pass   = 0;
   logic saw_yellow;

   phase_sequencer dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .tick              (tick),
      .car_sensor        (car_sensor),
      .pedestrian_button (pedestrian_button),
      .green_light       (green_light),
      .yellow_light      (yellow_light),
      .red_light         (red_light),
      .walk_light        (walk_light),
      .hand_light        (hand_light),
      .active_phase      (active_phase),
      .countdown_bcd     (countdown_bcd),
      .request_pending   (request_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
   endtask

   // Advance n clock edges, leaving time 1 unit past the last edge
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Asynchronous mid-cycle reset, then walk through the 2-tick all-red to phase 0 green
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      check("rst_red",    32'(red_light),       'hF);
      check("rst_green",  32'(green_light),     'h0);
      check("rst_yellow", 32'(yellow_light),    'h0);
      check("rst_walk",   32'(walk_light),      'h0);
      check("rst_hand",   32'(hand_light),      'hF);
      check("rst_bcd",    32'(countdown_bcd),   'h0);
      check("rst_active", 32'(active_phase),    'h0);
      check("rst_req",    32'(request_pending), 'h0);
      car_sensor        = '0;
      pedestrian_button = '0;
      tick              = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1);
      check("ar1_red",    32'(red_light),    'hF);
      check("ar1_green",  32'(green_light),  'h0);
      cyc(1);
      check("g0_green",   32'(green_light),  'h1);
      check("g0_red",     32'(red_light),    'hE);
      check("g0_active",  32'(active_phase), 'h0);
   endtask

   initial begin
      // Recall to phase 0 and rest without a conflicting request
      do_reset();
      saw_yellow = 1'b0;
      for (int i = 0; i < 110; i++) begin
         cyc(1);
         if (yellow_light != 4'h0) saw_yellow = 1'b1;
      end
      check("rest_no_yellow", 32'(saw_yellow),  'h0);
      check("rest_green",     32'(green_light), 'h1);

      // Frozen timebase still latches requests; release exits at once (elapsed saturated)
      tick = 1'b0;
      car_sensor[1] = 1'b1;
      cyc(1);
      car_sensor = '0;
      cyc(4);
      check("frz_green", 32'(green_light),     'h1);
      check("frz_req",   32'(request_pending), 'h2);
      tick = 1'b1;
      cyc(1);
      check("unfrz_yel", 32'(yellow_light), 'h1);

      // Min-green exit toward phase 2
      do_reset();
      cyc(3);
      car_sensor[2] = 1'b1;
      cyc(1);
      car_sensor = '0;
      check("min_req",     32'(request_pending), 'h4);
      cyc(5);
      check("min_g9",      32'(green_light),  'h1);
      check("min_y9",      32'(yellow_light), 'h0);
      cyc(1);
      check("min_y10",     32'(yellow_light), 'h1);
      check("min_g10",     32'(green_light),  'h0);
      cyc(3);
      check("min_y13",     32'(yellow_light), 'h1);
      cyc(1);
      check("min_ar14",    32'(red_light),    'hF);
      cyc(1);
      check("min_ar15",    32'(red_light),    'hF);
      cyc(1);
      check("min_g2",      32'(green_light),     'h4);
      check("min_act2",    32'(active_phase),    'h2);
      check("min_req_clr", 32'(request_pending), 'h0);

      // Mid-yellow asynchronous reset with phase 2 active and requests pending
      car_sensor = 4'b1010;
      cyc(10);
      check("pre_rst_yel", 32'(yellow_light), 'h4);
      cyc(1);
      check("pre_rst_act", 32'(active_phase),    'h2);
      check("pre_rst_req", 32'(request_pending), 'hA);
      do_reset();

      // Held car on phase 0 extends green to the max limit
      car_sensor = 4'b0011;
      cyc(10);
      check("max_g10",   32'(green_light),     'h1);
      check("max_y10",   32'(yellow_light),    'h0);
      check("max_req",   32'(request_pending), 'h2);
      cyc(29);
      check("max_g39",   32'(green_light),  'h1);
      cyc(1);
      check("max_y40",   32'(yellow_light), 'h1);
      cyc(6);
      check("max_g1",    32'(green_light),  'h2);
      check("max_act1",  32'(active_phase), 'h1);

      // Pedestrian on phase 3 while phase 1 green; cyclic search picks 3 before 0
      car_sensor = '0;
      pedestrian_button[3] = 1'b1;
      cyc(1);
      pedestrian_button = '0;
      check("ped_req",  32'(request_pending), 'h9);
      cyc(15);
      check("ped_g3",   32'(green_light),   'h8);
      check("ped_act3", 32'(active_phase),  'h3);
      check("ped_walk", 32'(walk_light),    'h8);
      check("ped_hand", 32'(hand_light),    'h7);
      check("ped_bcd7", 32'(countdown_bcd), 'h07);
      for (int k = 1; k <= 6; k++) begin
         cyc(1);
         check("ped_bcd",    32'(countdown_bcd), 32'(7 - k));
         check("ped_walk_k", 32'(walk_light),    'h8);
      end
      cyc(1);
      check("ped_bcd0",  32'(countdown_bcd), 'h00);
      check("ped_walk0", 32'(walk_light),    'h0);
      check("ped_hand0", 32'(hand_light),    'hF);

      // Phase 2 active with requests on 1 and 3: served 3 then 1
      do_reset();
      car_sensor = 4'b0100;
      cyc(1);
      car_sensor = '0;
      cyc(15);
      check("ord_g2",   32'(green_light),  'h4);
      car_sensor = 4'b1010;
      cyc(1);
      car_sensor = '0;
      cyc(15);
      check("ord_g3",   32'(green_light),  'h8);
      check("ord_act3", 32'(active_phase), 'h3);
      cyc(16);
      check("ord_g1",   32'(green_light),  'h2);
      check("ord_act1", 32'(active_phase), 'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
